// File: rtl/vrf_write_arbiter.sv
// rtl/vrf_write_arbiter.sv - rotating-priority arbiter sharing one VRF write port
// Optional starvation override enabled by defining VRF_WRITE_ARB_AGE_LIMIT_EN.
module vrf_write_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int MAX_WAIT = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*5-1:0]   req_vd,
  input  logic [NUM_REQ*6-1:0]   req_offset,
  input  logic [NUM_REQ*4-1:0]   req_mask,
  input  logic [NUM_REQ*32-1:0]  req_data,
  input  logic [NUM_REQ-1:0]     req_last,
  input  logic [NUM_REQ*3-1:0]   req_instructionIndex,
  input  logic                   vrfWriteRequest_ready,
  output logic                   vrfWriteRequest_valid,
  output logic [4:0]             vrfWriteRequest_bits_vd,
  output logic [5:0]             vrfWriteRequest_bits_offset,
  output logic [3:0]             vrfWriteRequest_bits_mask,
  output logic [31:0]            vrfWriteRequest_bits_data,
  output logic                   vrfWriteRequest_bits_last,
  output logic [2:0]             vrfWriteRequest_bits_instructionIndex,
  output logic [7:0]             writeDone
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_WAIT < 1) begin : g_param_check
    $error("vrf_write_arbiter: unsupported NUM_REQ or MAX_WAIT");
  end

  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   rr_idx;
  logic               rr_any;
  logic [PTR_W-1:0]   grant_idx;
  logic               grant_any;
  logic [NUM_REQ-1:0] grant_onehot;
  logic [NUM_REQ-1:0] xfer;
  logic               xfer_any;
  logic               load;

  logic [4:0]  sel_vd;
  logic [5:0]  sel_offset;
  logic [3:0]  sel_mask;
  logic [31:0] sel_data;
  logic        sel_last;
  logic [2:0]  sel_index;

  assign load = ~vrfWriteRequest_valid | vrfWriteRequest_ready;

  // Scan from ptr downwards in priority; the last hit assigned is the nearest to ptr.
  always_comb begin
    logic [PTR_W:0] pos;
    rr_any = 1'b0;
    rr_idx = ptr;
    pos    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      pos = {1'b0, ptr} + (PTR_W+1)'(k);
      if (pos >= (PTR_W+1)'(NUM_REQ)) begin
        pos = pos - (PTR_W+1)'(NUM_REQ);
      end
      if (req_valid[pos[PTR_W-1:0]]) begin
        rr_any = 1'b1;
        rr_idx = pos[PTR_W-1:0];
      end
    end
  end

`ifdef VRF_WRITE_ARB_AGE_LIMIT_EN
  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  logic [CNT_W-1:0] wait_cnt [NUM_REQ];
  logic             old_any;
  logic [PTR_W-1:0] old_idx;

  // Starved requesters win outright, lowest index first.
  always_comb begin
    old_any = 1'b0;
    old_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[k] && (wait_cnt[k] >= CNT_W'(MAX_WAIT))) begin
        old_any = 1'b1;
        old_idx = PTR_W'(k);
      end
    end
  end

  assign grant_any = old_any | rr_any;
  assign grant_idx = old_any ? old_idx : rr_idx;

  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (reset) begin
        wait_cnt[i] <= '0;
      end else if (!req_valid[i] || xfer[i]) begin
        wait_cnt[i] <= '0;
      end else if (load && !grant_onehot[i] && (wait_cnt[i] < CNT_W'(MAX_WAIT))) begin
        wait_cnt[i] <= wait_cnt[i] + CNT_W'(1);
      end
    end
  end
`else
  assign grant_any = rr_any;
  assign grant_idx = rr_idx;
`endif

  always_comb begin
    grant_onehot = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      grant_onehot[k] = grant_any && (grant_idx == PTR_W'(k));
    end
  end

  assign req_ready = (load && !reset) ? grant_onehot : '0;
  assign xfer      = req_valid & req_ready;
  assign xfer_any  = |xfer;

  always_comb begin
    sel_vd     = '0;
    sel_offset = '0;
    sel_mask   = '0;
    sel_data   = '0;
    sel_last   = 1'b0;
    sel_index  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_idx == PTR_W'(k)) begin
        sel_vd     = req_vd[k*5 +: 5];
        sel_offset = req_offset[k*6 +: 6];
        sel_mask   = req_mask[k*4 +: 4];
        sel_data   = req_data[k*32 +: 32];
        sel_last   = req_last[k];
        sel_index  = req_instructionIndex[k*3 +: 3];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr <= '0;
    end else if (xfer_any) begin
      ptr <= (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);
    end
  end

  // Fields only move on a transfer, so they stay put while the VRF stalls.
  always_ff @(posedge clock) begin
    if (reset) begin
      vrfWriteRequest_valid                 <= 1'b0;
      vrfWriteRequest_bits_vd               <= '0;
      vrfWriteRequest_bits_offset           <= '0;
      vrfWriteRequest_bits_mask             <= '0;
      vrfWriteRequest_bits_data             <= '0;
      vrfWriteRequest_bits_last             <= 1'b0;
      vrfWriteRequest_bits_instructionIndex <= '0;
    end else if (load) begin
      vrfWriteRequest_valid <= xfer_any;
      if (xfer_any) begin
        vrfWriteRequest_bits_vd               <= sel_vd;
        vrfWriteRequest_bits_offset           <= sel_offset;
        vrfWriteRequest_bits_mask             <= sel_mask;
        vrfWriteRequest_bits_data             <= sel_data;
        vrfWriteRequest_bits_last             <= sel_last;
        vrfWriteRequest_bits_instructionIndex <= sel_index;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      writeDone <= '0;
    end else if (vrfWriteRequest_valid && vrfWriteRequest_ready && vrfWriteRequest_bits_last) begin
      writeDone <= 8'd1 << vrfWriteRequest_bits_instructionIndex;
    end else begin
      writeDone <= '0;
    end
  end

endmodule

// File: tb/tb_vrf_write_arbiter.sv
// tb/tb_vrf_write_arbiter.sv - scoreboard bench for vrf_write_arbiter
// Starvation expectations follow VRF_WRITE_ARB_AGE_LIMIT_EN.
module tb_vrf_write_arbiter;
  localparam int N = 4;

  typedef struct packed {
    logic [4:0]  vd;
    logic [5:0]  offset;
    logic [3:0]  mask;
    logic [31:0] data;
    logic        last;
    logic [2:0]  idx;
  } beat_t;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [N-1:0]  req_valid = '0;
  logic [N-1:0]  req_ready;
  logic [N*5-1:0]  req_vd;
  logic [N*6-1:0]  req_offset;
  logic [N*4-1:0]  req_mask;
  logic [N*32-1:0] req_data;
  logic [N-1:0]    req_last;
  logic [N*3-1:0]  req_instructionIndex;
  logic          vrf_ready = 1'b0;
  logic          out_valid;
  logic [4:0]    out_vd;
  logic [5:0]    out_offset;
  logic [3:0]    out_mask;
  logic [31:0]   out_data;
  logic          out_last;
  logic [2:0]    out_idx;
  logic [7:0]    writeDone;

  beat_t src [N];
  beat_t exp_q [$];
  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  vrf_write_arbiter #(.NUM_REQ(N), .MAX_WAIT(2)) dut (
    .clock(clock),
    .reset(reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_vd(req_vd),
    .req_offset(req_offset),
    .req_mask(req_mask),
    .req_data(req_data),
    .req_last(req_last),
    .req_instructionIndex(req_instructionIndex),
    .vrfWriteRequest_ready(vrf_ready),
    .vrfWriteRequest_valid(out_valid),
    .vrfWriteRequest_bits_vd(out_vd),
    .vrfWriteRequest_bits_offset(out_offset),
    .vrfWriteRequest_bits_mask(out_mask),
    .vrfWriteRequest_bits_data(out_data),
    .vrfWriteRequest_bits_last(out_last),
    .vrfWriteRequest_bits_instructionIndex(out_idx),
    .writeDone(writeDone)
  );

  always_comb begin
    req_vd = '0;
    req_offset = '0;
    req_mask = '0;
    req_data = '0;
    req_last = '0;
    req_instructionIndex = '0;
    for (int i = 0; i < N; i++) begin
      req_vd[i*5 +: 5] = src[i].vd;
      req_offset[i*6 +: 6] = src[i].offset;
      req_mask[i*4 +: 4] = src[i].mask;
      req_data[i*32 +: 32] = src[i].data;
      req_last[i] = src[i].last;
      req_instructionIndex[i*3 +: 3] = src[i].idx;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic sample();
    @(negedge clock);
  endtask

  task automatic default_src(input int i);
    src[i].vd = 5'(10 + i);
    src[i].offset = 6'(20 + i);
    src[i].mask = 4'(i + 1);
    src[i].data = 32'hA000_0000 + 32'(i);
    src[i].last = 1'b0;
    src[i].idx = 3'(i);
  endtask

  // Monitor: every beat the VRF accepts must be the oldest expected one.
  always @(negedge clock) begin
    beat_t got;
    beat_t e;
    if (!reset && out_valid && vrf_ready) begin
      got = '{vd: out_vd, offset: out_offset, mask: out_mask, data: out_data,
              last: out_last, idx: out_idx};
      check("sb_has_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("beat", 64'(got), 64'(e));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    logic [N-1:0] starve_exp;
    for (int i = 0; i < N; i++) default_src(i);
    req_valid = '1;
    vrf_ready = 1'b1;

    repeat (2) begin
      sample();
      check("reset_ready", 64'(req_ready), 64'd0);
      check("reset_valid", 64'(out_valid), 64'd0);
      check("reset_done", 64'(writeDone), 64'd0);
    end
    step();
    reset = 1'b0;

    for (int k = 0; k < 5; k++) begin
      sample();
      check("rr_grant", 64'(req_ready), 64'(4'b0001 << (k % 4)));
      exp_q.push_back(src[k % 4]);
      step();
    end
    req_valid = '0;
    sample();
    check("idle_ready", 64'(req_ready), 64'd0);
    step();
    sample();
    check("drain_valid", 64'(out_valid), 64'd0);

    step();
    src[2].data = 32'hDEAD_BEEF;
    req_valid = 4'b1100;
    vrf_ready = 1'b0;
    sample();
    check("bp_grant2", 64'(req_ready), 64'b0100);
    exp_q.push_back(src[2]);
    step();
    req_valid = 4'b1000;
    repeat (3) begin
      sample();
      check("bp_ready", 64'(req_ready), 64'd0);
      check("bp_valid", 64'(out_valid), 64'd1);
      check("bp_data", 64'(out_data), 64'hDEAD_BEEF);
      step();
    end
    vrf_ready = 1'b1;
    sample();
    check("bp_grant3", 64'(req_ready), 64'b1000);
    exp_q.push_back(src[3]);
    step();
    req_valid = '0;
    sample();
    step();
    sample();
    check("bp_empty", 64'(out_valid), 64'd0);

    step();
    src[0].last = 1'b1;
    src[0].idx = 3'd5;
    src[0].mask = 4'd0;
    req_valid = 4'b0001;
    sample();
    check("wrap_grant0", 64'(req_ready), 64'b0001);
    exp_q.push_back(src[0]);
    step();
    req_valid = '0;
    sample();
    check("done_before", 64'(writeDone), 64'd0);
    step();
    sample();
    check("done_pulse", 64'(writeDone), 64'h20);
    step();
    sample();
    check("done_after", 64'(writeDone), 64'd0);
    default_src(0);

    step();
    src[1].last = 1'b1;
    src[1].idx = 3'd3;
    req_valid = 4'b0010;
    vrf_ready = 1'b0;
    sample();
    check("mid_grant1", 64'(req_ready), 64'b0010);
    step();
    req_valid = '1;
    reset = 1'b1;
    vrf_ready = 1'b1;
    sample();
    check("mid_reset_ready", 64'(req_ready), 64'd0);
    step();
    reset = 1'b0;
    sample();
    check("mid_valid", 64'(out_valid), 64'd0);
    check("mid_done", 64'(writeDone), 64'd0);
    check("mid_ptr0", 64'(req_ready), 64'b0001);
    exp_q.push_back(src[0]);
    step();
    req_valid = '0;
    sample();
    check("mid_done_later", 64'(writeDone), 64'd0);
    step();
    sample();
    check("mid_empty", 64'(out_valid), 64'd0);
    default_src(1);

`ifdef VRF_WRITE_ARB_AGE_LIMIT_EN
    starve_exp = 4'b0010;
`else
    starve_exp = 4'b0001;
`endif
    step();
    req_valid = 4'b0010;
    sample();
    check("st_grant1", 64'(req_ready), 64'b0010);
    exp_q.push_back(src[1]);
    step();
    req_valid = 4'b1110;
    sample();
    check("st_grant2", 64'(req_ready), 64'b0100);
    exp_q.push_back(src[2]);
    step();
    sample();
    check("st_grant3", 64'(req_ready), 64'b1000);
    exp_q.push_back(src[3]);
    step();
    req_valid = 4'b1111;
    sample();
    check("st_override", 64'(req_ready), 64'(starve_exp));
    exp_q.push_back(starve_exp[1] ? src[1] : src[0]);
    step();
    req_valid = '0;
    sample();
    step();
    sample();
    check("final_empty", 64'(out_valid), 64'd0);
    check("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vrf_write_arbiter.md
# vrf_write_arbiter

Shares one VRF write port among `NUM_REQ` lane write-queue requesters: stage-3 write queues, cross-lane write return and the LSU. Arbitration is rotating-priority, with one beat granted per cycle. Output goes through a one-entry registered stage. The block also pulses a per-instruction completion flag when a `last` beat reaches the VRF. It sits between the lane pipeline write queues and the VRF bank write interface.

## Interface
- `NUM_REQ`, 4: number of requesters (2..8).
- `MAX_WAIT`, 8: starvation threshold in cycles; used only with the age feature.
- `clock`  in  1  single clock; all logic is rising-edge.
- `reset`  in  1  synchronous, active-high.
- `req_valid`  in  NUM_REQ  per-requester beat valid.
- `req_ready`  out  NUM_REQ  per-requester accept; at most one bit set per cycle.
- `req_vd`  in  NUM_REQ*5  packed; requester i occupies bits [5i+4:5i].
- `req_offset`  in  NUM_REQ*6  packed.
- `req_mask`  in  NUM_REQ*4  packed.
- `req_data`  in  NUM_REQ*32  packed.
- `req_last`  in  NUM_REQ  last beat of the instruction.
- `req_instructionIndex`  in  NUM_REQ*3  packed.
- `vrfWriteRequest_ready`  in  1  VRF accepts the beat.
- `vrfWriteRequest_valid`  out  1  registered.
- `vrfWriteRequest_bits_vd` / `_offset` / `_mask` / `_data` / `_last` / `_instructionIndex`  out  5/6/4/32/1/3  registered beat fields.
- `writeDone`  out  8  one-cycle pulse, one-hot on instructionIndex; registered.

## Operation
- **Output register.**
  - Output register `R` holds `out_valid` plus the beat fields.
  - `load = ~out_valid | vrfWriteRequest_ready`.
- **Ready and grant.**
  - `req_ready[g] = load & grant_onehot[g]`.
  - A transfer on requester g is `req_valid[g] & req_ready[g]`.
  - The transfer copies requester g's fields into `R` and sets `out_valid`.
- **Emptying R.** If `load` is high and there is no transfer, `out_valid` clears.
- **Round-robin.**
  - Pointer `ptr` has width clog2(NUM_REQ).
  - Grant goes to the first valid requester at index ptr, ptr+1, … mod NUM_REQ.
  - After a transfer, `ptr` becomes (g+1) mod NUM_REQ.
  - With no transfer, `ptr` holds.
  - Grant is combinational from `req_valid` and `ptr`; no requester is granted while `load` is low.
- **writeDone.** When `vrfWriteRequest_valid & vrfWriteRequest_ready & vrfWriteRequest_bits_last`, the next cycle `writeDone` has bit `instructionIndex` set and all other bits 0. Otherwise `writeDone` is 0.
- **Data and mask.** Data and mask pass through unchanged. A mask of 0 is still forwarded as a beat.
- **Field stability.** Fields in `R` hold while `out_valid & ~vrfWriteRequest_ready`.

## Timing
- **Reset values:**
  - `out_valid` = 0.
  - `ptr` = 0.
  - `writeDone` = 0.
  - All beat fields = 0.
  - Wait counters = 0.
  - `req_ready` = 0 during reset.
- **Latency.** A request accepted in cycle t appears on `vrfWriteRequest_*` in cycle t+1.
- **Throughput.** One beat per cycle when `vrfWriteRequest_ready` is held high.
- **Back-pressure.**
  - With `out_valid=1` and ready=0, all `req_ready`=0.
  - Requesters keep valid and fields stable (standard valid/ready; valid must not depend on ready).
- **Simultaneous drain and fill.** `out_valid=1`, ready=1 and a pending request: `R` reloads in the same edge with no bubble.
- **Empty.** No requester valid → no grant, `ptr` unchanged, `R` empties on the next `load`.
- **Wrap.** `ptr` = NUM_REQ-1 followed by a grant to NUM_REQ-1 wraps `ptr` to 0.
- **Reset mid-operation.** An in-flight beat in `R` is dropped and no `writeDone` is emitted for it. Requesters must re-present after reset.

## Configuration
- **Macro `VRF_WRITE_ARB_AGE_LIMIT_EN` defined:**
  - Each requester has a saturating wait counter of width clog2(MAX_WAIT+1).
  - The counter increments in cycles where `req_valid[i]=1`, `load=1` and i is not granted.
  - It clears on a transfer for i, or when `req_valid[i]=0`.
  - Any requester with counter ≥ MAX_WAIT overrides round-robin. The lowest index among such requesters wins.
  - `ptr` still updates to g+1 after an override transfer.
- **Macro undefined:** pure round-robin; no counters are instantiated.

## Test plan
- **Reset.** Assert reset 2 cycles with all `req_valid`=1 → `req_ready`=0, `vrfWriteRequest_valid`=0 and `writeDone`=0 during reset; first grant goes to requester 0 after release.
- **Round-robin order.** All 4 valid continuously, VRF ready=1 → grants 0,1,2,3,0 on consecutive cycles; output vd values match each source one cycle later.
- **Back-pressure.** Requester 2 presents data=0xDEADBEEF, VRF ready=0 for 3 cycles → output holds 0xDEADBEEF with valid=1 and all `req_ready`=0; ready=1 → beat retires, requester 3 is granted the same cycle.
- **Completion pulse.** Beat with last=1, instructionIndex=5 accepted at the VRF → `writeDone`=8'b0010_0000 for exactly one cycle.
- **Starvation (macro defined, MAX_WAIT=2).** Forced ordering with requester 1 waiting; its counter reaching 2 → requester 1 granted ahead of the round-robin pick; macro undefined → strict round-robin order.
- **Reset mid-operation.** Reset while `out_valid=1` with last=1 → no `writeDone` pulse; `ptr` returns to 0.
